// File: rtl/sa_out_collector.sv
// sa_out_collector: de-skews systolic-array column outputs into aligned rows,
// buffers them in a small FIFO and hands them downstream over valid/ready.
//
// Ports:
//   I_CLK, I_RST_N     clock, asynchronous active-low reset
//   I_START_FLAG       start a new matrix (clears FIFO, delay lines, counters, OVF)
//   I_SHIFT, I_DATA    SA shift pulse and bottom-row outputs (lane j = [j*16 +: 16])
//   I_RDY              downstream ready
//   O_VLD, O_DATA      FIFO head valid and aligned row
//   O_ROW_IDX          row index of the FIFO head
//   O_BUSY             FSM not idle
//   O_DONE             1-cycle pulse once the last row has left the FIFO
//   O_OVF              sticky: a row was dropped on a full FIFO
//
// Build option: define SA_COLLECT_RELU_EN to clamp negative lanes to zero
// before the FIFO write.
module sa_out_collector #(
    parameter int N     = 64,
    parameter int S     = 64,
    parameter int ROWS  = 64,
    parameter int DEPTH = 4
) (
    input  logic                    I_CLK,
    input  logic                    I_RST_N,
    input  logic                    I_START_FLAG,
    input  logic                    I_SHIFT,
    input  logic [N*16-1:0]         I_DATA,
    input  logic                    I_RDY,
    output logic                    O_VLD,
    output logic [N*16-1:0]         O_DATA,
    output logic [$clog2(ROWS)-1:0] O_ROW_IDX,
    output logic                    O_BUSY,
    output logic                    O_DONE,
    output logic                    O_OVF
);

    localparam int W  = S + N - 2;
    localparam int KW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
        S_COLL,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [KW-1:0]   k_q, k_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N*16-1:0] mem_q [DEPTH];
    logic [N*16-1:0] mem_d [DEPTH];
    logic [RW-1:0]   idx_q [DEPTH];
    logic [RW-1:0]   idx_d [DEPTH];
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic            advance;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;
    logic [N*16-1:0] aligned;
    logic [N*16-1:0] wr_row;

    // A start in the same cycle as a shift wins: the shift is discarded.
    assign advance  = I_SHIFT && !I_START_FLAG &&
                      (state_q == S_WARM || state_q == S_COLL);
    assign push_req = I_SHIFT && !I_START_FLAG && (state_q == S_COLL);
    assign full     = (cnt_q == CW'(DEPTH));
    assign pop      = O_VLD && I_RDY && !I_START_FLAG;
    // The SA cannot stall, so a full FIFO only takes the row if it pops too.
    assign push     = push_req && (!full || pop);

    // Lane j lags lane N-1 by N-1-j shifts; equalise with that many stages.
    for (genvar j = 0; j < N; j++) begin : g_lane
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j*16 +: 16] = I_DATA[j*16 +: 16];
        end else begin : g_dly
            logic [15:0] dl_q [D];
            logic [15:0] dl_d [D];

            always_comb begin
                for (int i = 0; i < D; i++) begin
                    dl_d[i] = dl_q[i];
                end
                if (I_START_FLAG) begin
                    for (int i = 0; i < D; i++) begin
                        dl_d[i] = '0;
                    end
                end else if (advance) begin
                    dl_d[0] = I_DATA[j*16 +: 16];
                    for (int i = 1; i < D; i++) begin
                        dl_d[i] = dl_q[i-1];
                    end
                end
            end

            always_ff @(posedge I_CLK or negedge I_RST_N) begin
                if (!I_RST_N) begin
                    for (int i = 0; i < D; i++) begin
                        dl_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < D; i++) begin
                        dl_q[i] <= dl_d[i];
                    end
                end
            end

            assign aligned[j*16 +: 16] = dl_q[D-1];
        end
    end

    always_comb begin
        wr_row = aligned;
`ifdef SA_COLLECT_RELU_EN
        for (int j = 0; j < N; j++) begin
            if (aligned[j*16 + 15]) begin
                wr_row[j*16 +: 16] = 16'h0000;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            idx_d[i] = idx_q[i];
        end

        if (I_START_FLAG) begin
            state_d = (W == 0) ? S_COLL : S_WARM;
            k_d     = '0;
            row_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_q] = wr_row;
                idx_d[wr_q] = row_q;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!push && pop) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (push_req && !push) begin
                ovf_d = 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_WARM: begin
                    if (I_SHIFT) begin
                        k_d = k_q + 1'b1;
                        if (k_q == KW'(W - 1)) begin
                            state_d = S_COLL;
                        end
                    end
                end
                S_COLL: begin
                    // Row counter advances even when the row is dropped.
                    if (I_SHIFT) begin
                        row_d = row_q + 1'b1;
                        if (row_q == RW'(ROWS - 1)) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_d == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            row_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
                idx_q[i] <= idx_d[i];
            end
        end
    end

    assign O_VLD     = (cnt_q != '0);
    assign O_DATA    = mem_q[rd_q];
    assign O_ROW_IDX = idx_q[rd_q];
    assign O_BUSY    = (state_q != S_IDLE);
    assign O_DONE    = done_q;
    assign O_OVF     = ovf_q;

endmodule

// File: tb/tb_sa_out_collector.sv
// Bench for sa_out_collector with N=4, S=2, ROWS=3, DEPTH=2 (W=4).
// Scoreboard of expected rows is compared at the FIFO head each cycle.
module tb_sa_out_collector;

    localparam int N     = 4;
    localparam int S     = 2;
    localparam int ROWS  = 3;
    localparam int DEPTH = 2;
    localparam int W     = S + N - 2;

    typedef struct packed {
        logic [1:0]  idx;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        I_RST_N;
    logic        I_START_FLAG;
    logic        I_SHIFT;
    logic [63:0] I_DATA;
    logic        I_RDY;
    logic        O_VLD;
    logic [63:0] O_DATA;
    logic [1:0]  O_ROW_IDX;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_OVF;

    int   checks    = 0;
    int   failures  = 0;
    int   rows_seen = 0;
    int   k_m       = 0;
    bit   m_on      = 0;
    bit   mon_en    = 0;
    bit   relu_pat  = 0;
    exp_t exp_q[$];

    sa_out_collector #(
        .N(N), .S(S), .ROWS(ROWS), .DEPTH(DEPTH)
    ) dut (
        .I_CLK(clk),
        .I_RST_N(I_RST_N),
        .I_START_FLAG(I_START_FLAG),
        .I_SHIFT(I_SHIFT),
        .I_DATA(I_DATA),
        .I_RDY(I_RDY),
        .O_VLD(O_VLD),
        .O_DATA(O_DATA),
        .O_ROW_IDX(O_ROW_IDX),
        .O_BUSY(O_BUSY),
        .O_DONE(O_DONE),
        .O_OVF(O_OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pat(int k);
        logic [63:0] v;
        int jj;
        for (int j = 0; j < N; j++) begin
            jj = j;
            if (relu_pat) v[j*16 +: 16] = 16'hE000;
            else          v[j*16 +: 16] = {k[7:0], jj[7:0]};
        end
        return v;
    endfunction

    function automatic exp_t mk_row(int r);
        exp_t e;
        int kk;
        int jj;
        e.idx = r[1:0];
        for (int j = 0; j < N; j++) begin
            kk = r + W - (N - 1 - j);
            jj = j;
            if (relu_pat) begin
`ifdef SA_COLLECT_RELU_EN
                e.data[j*16 +: 16] = 16'h0000;
`else
                e.data[j*16 +: 16] = 16'hE000;
`endif
            end else begin
                e.data[j*16 +: 16] = {kk[7:0], jj[7:0]};
            end
        end
        return e;
    endfunction

    // Scoreboard at the FIFO head; pops when the handshake fires.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (O_VLD !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL sb_vld got=%b exp=%b", O_VLD, exp_q.size() != 0);
            end
            if (O_VLD && exp_q.size() != 0) begin
                checks++;
                if (O_DATA !== exp_q[0].data || O_ROW_IDX !== exp_q[0].idx) begin
                    failures++;
                    $display("FAIL sb_row got=%h/%0d exp=%h/%0d",
                             O_DATA, O_ROW_IDX, exp_q[0].data, exp_q[0].idx);
                end
                if (I_RDY) begin
                    void'(exp_q.pop_front());
                    rows_seen++;
                end
            end
        end
    end

    // Entered and left at posedge+1; the model updates after the head check.
    task automatic drive(input logic sh, input logic rdy, input logic st);
        I_SHIFT      = sh;
        I_RDY        = rdy;
        I_START_FLAG = st;
        I_DATA       = sh ? pat(k_m) : '0;
        @(negedge clk);
        #1;
        if (st) begin
            exp_q.delete();
            k_m  = 0;
            m_on = 1;
        end else if (sh && m_on) begin
            if (k_m >= W) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(mk_row(k_m - W));
            end
            k_m++;
            if (k_m == W + ROWS) m_on = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        I_RST_N      = 1'b0;
        I_START_FLAG = 1'b0;
        I_SHIFT      = 1'b0;
        I_DATA       = '0;
        I_RDY        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({O_VLD, O_BUSY, O_DONE, O_OVF} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {O_VLD, O_BUSY, O_DONE, O_OVF});
        end
        checks++;
        if (O_DATA !== 64'h0 || O_ROW_IDX !== 2'd0) begin
            failures++;
            $display("FAIL reset_data got=%h/%0d exp=0/0", O_DATA, O_ROW_IDX);
        end
        I_RST_N = 1'b1;
        mon_en  = 1'b1;
        drive(1, 1, 0);
        checks++;
        if (O_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL idle_shift busy got=%b exp=0", O_BUSY);
        end
    endtask

    task automatic test_alignment();
        int base;
        base = rows_seen;
        drive(0, 1, 1);
        checks++;
        if (O_BUSY !== 1'b1 || O_VLD !== 1'b0) begin
            failures++;
            $display("FAIL align_start busy/vld got=%b%b exp=10", O_BUSY, O_VLD);
        end
        for (int k = 0; k < 7; k++) begin
            drive(1, 1, 0);
            if (k == 3) begin
                checks++;
                if (O_VLD !== 1'b0) begin
                    failures++;
                    $display("FAIL align_warm vld got=%b exp=0", O_VLD);
                end
            end
            if (k == 4) begin
                checks++;
                if (O_VLD !== 1'b1 || O_DATA !== 64'h0403_0302_0201_0100) begin
                    failures++;
                    $display("FAIL align_row0 got=%b/%h exp=1/0403030202010100",
                             O_VLD, O_DATA);
                end
            end
        end
        checks++;
        if (O_DONE !== 1'b0) begin
            failures++;
            $display("FAIL align_early_done got=%b exp=0", O_DONE);
        end
        drive(0, 1, 0);
        checks++;
        if (O_DONE !== 1'b1 || O_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL align_done done/busy got=%b%b exp=10", O_DONE, O_BUSY);
        end
        drive(0, 1, 0);
        checks++;
        if (O_DONE !== 1'b0 || rows_seen - base != 3) begin
            failures++;
            $display("FAIL align_end done/rows got=%b/%0d exp=0/3",
                     O_DONE, rows_seen - base);
        end
    endtask

    task automatic test_backpressure();
        int base;
        base = rows_seen;
        drive(0, 0, 1);
        for (int k = 0; k < 7; k++) drive(1, 0, 0);
        checks++;
        if (O_OVF !== 1'b1 || O_VLD !== 1'b1 || O_ROW_IDX !== 2'd0) begin
            failures++;
            $display("FAIL bp_drop ovf/vld/idx got=%b/%b/%0d exp=1/1/0",
                     O_OVF, O_VLD, O_ROW_IDX);
        end
        repeat (3) drive(0, 0, 0);
        drive(0, 1, 0);
        checks++;
        if (O_DONE !== 1'b0 || O_ROW_IDX !== 2'd1) begin
            failures++;
            $display("FAIL bp_pop0 done/idx got=%b/%0d exp=0/1", O_DONE, O_ROW_IDX);
        end
        drive(0, 1, 0);
        checks++;
        if (O_DONE !== 1'b1 || O_OVF !== 1'b1 || rows_seen - base != 2) begin
            failures++;
            $display("FAIL bp_done done/ovf/rows got=%b/%b/%0d exp=1/1/2",
                     O_DONE, O_OVF, rows_seen - base);
        end
    endtask

    task automatic test_full_pop();
        int base;
        base = rows_seen;
        drive(0, 0, 1);
        checks++;
        if (O_OVF !== 1'b0) begin
            failures++;
            $display("FAIL fp_ovf_clear got=%b exp=0", O_OVF);
        end
        for (int k = 0; k < 6; k++) drive(1, 0, 0);
        drive(1, 1, 0);
        checks++;
        if (O_OVF !== 1'b0 || O_ROW_IDX !== 2'd1) begin
            failures++;
            $display("FAIL fp_push_pop ovf/idx got=%b/%0d exp=0/1", O_OVF, O_ROW_IDX);
        end
        drive(0, 1, 0);
        checks++;
        if (O_DONE !== 1'b0 || O_ROW_IDX !== 2'd2) begin
            failures++;
            $display("FAIL fp_row2 done/idx got=%b/%0d exp=0/2", O_DONE, O_ROW_IDX);
        end
        drive(0, 1, 0);
        checks++;
        if (O_DONE !== 1'b1 || rows_seen - base != 3) begin
            failures++;
            $display("FAIL fp_done done/rows got=%b/%0d exp=1/3",
                     O_DONE, rows_seen - base);
        end
    endtask

    task automatic test_restart();
        drive(0, 0, 1);
        for (int k = 0; k < 6; k++) drive(1, 0, 0);
        checks++;
        if (O_VLD !== 1'b1) begin
            failures++;
            $display("FAIL rs_pre vld got=%b exp=1", O_VLD);
        end
        drive(1, 0, 1);
        checks++;
        if (O_VLD !== 1'b0 || O_OVF !== 1'b0 || O_BUSY !== 1'b1) begin
            failures++;
            $display("FAIL rs_flush vld/ovf/busy got=%b/%b/%b exp=0/0/1",
                     O_VLD, O_OVF, O_BUSY);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0);
            checks++;
            if (O_VLD !== (i == 4)) begin
                failures++;
                $display("FAIL rs_latency shift%0d vld got=%b exp=%b",
                         i, O_VLD, i == 4);
            end
        end
        checks++;
        if (O_ROW_IDX !== 2'd0) begin
            failures++;
            $display("FAIL rs_idx got=%0d exp=0", O_ROW_IDX);
        end
        repeat (2) drive(1, 1, 0);
        drive(0, 1, 0);
        checks++;
        if (O_DONE !== 1'b1) begin
            failures++;
            $display("FAIL rs_done got=%b exp=1", O_DONE);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 1);
        for (int k = 0; k < 5; k++) drive(1, 0, 0);
        checks++;
        if (O_VLD !== 1'b1) begin
            failures++;
            $display("FAIL rm_pre vld got=%b exp=1", O_VLD);
        end
        mon_en = 1'b0;
        #2;
        I_RST_N = 1'b0;
        #1;
        checks++;
        if ({O_VLD, O_BUSY, O_DONE, O_OVF} !== 4'b0000) begin
            failures++;
            $display("FAIL rm_async got=%b exp=0000", {O_VLD, O_BUSY, O_DONE, O_OVF});
        end
        exp_q.delete();
        m_on    = 0;
        I_SHIFT = 1'b1;
        @(posedge clk);
        #1;
        I_RST_N = 1'b1;
        mon_en  = 1'b1;
        repeat (6) drive(1, 1, 0);
        checks++;
        if (O_VLD !== 1'b0 || O_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL rm_ignore vld/busy got=%b/%b exp=0/0", O_VLD, O_BUSY);
        end
    endtask

    task automatic test_relu();
        relu_pat = 1;
        drive(0, 1, 1);
        for (int k = 0; k < 5; k++) drive(1, 1, 0);
        checks++;
`ifdef SA_COLLECT_RELU_EN
        if (O_DATA !== 64'h0) begin
            failures++;
            $display("FAIL relu_lanes got=%h exp=0000000000000000", O_DATA);
        end
`else
        if (O_DATA !== {4{16'hE000}}) begin
            failures++;
            $display("FAIL relu_lanes got=%h exp=e000e000e000e000", O_DATA);
        end
`endif
        repeat (2) drive(1, 1, 0);
        drive(0, 1, 0);
        checks++;
        if (O_DONE !== 1'b1) begin
            failures++;
            $display("FAIL relu_done got=%b exp=1", O_DONE);
        end
        relu_pat = 0;
    endtask

    initial begin
        test_reset();
        test_alignment();
        test_backpressure();
        test_full_pop();
        test_restart();
        test_reset_mid();
        test_relu();
        drive(0, 1, 0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
